// File: rtl/tri_raster_engine_if.sv
// Command and framebuffer-write bundle for tri_raster_engine.
// The engine uses the slave modport; the vertex source and framebuffer side use master.
interface tri_raster_engine_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 4
);
    logic               start;
    logic [X_W-1:0]     v0x, v1x, v2x;
    logic [Y_W-1:0]     v0y, v1y, v2y;
    logic [COLOR_W-1:0] color;
    logic               busy;
    logic               done;
    logic [X_W-1:0]     fb_x;
    logic [Y_W-1:0]     fb_y;
    logic [COLOR_W-1:0] data;
    logic               fb_we;
    logic               fb_ready;

    modport master (
        output start, v0x, v1x, v2x, v0y, v1y, v2y, color, fb_ready,
        input  busy, done, fb_x, fb_y, data, fb_we
    );

    modport slave (
        input  start, v0x, v1x, v2x, v0y, v1y, v2y, color, fb_ready,
        output busy, done, fb_x, fb_y, data, fb_we
    );
endinterface

// File: rtl/tri_raster_engine.sv
// Triangle rasterizer: clamped bounding-box walk with incremental edge functions.
// Define RU_BACKFACE_CULL_EN to drop negative-area triangles instead of flipping them.
module tri_raster_engine #(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOR_W  = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               areset,
    tri_raster_engine_if.slave bus
);
    localparam int EW = ((X_W > Y_W) ? X_W : Y_W) * 2 + 4;
    localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H - 1);

    typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, DONE} state_t;
    state_t state, state_next;

    logic [X_W-1:0]       vx [3];
    logic [Y_W-1:0]       vy [3];
    logic [COLOR_W-1:0]   color_q;
    logic [X_W-1:0]       xmin, xmax, x;
    logic [Y_W-1:0]       ymin, ymax, y;
    logic signed [EW-1:0] dx [3], dy [3], e [3], row [3];

    logic signed [EW-1:0] sx [3], sy [3], dx_raw [3], dy_raw [3], dx_c [3], dy_c [3];
    logic signed [EW-1:0] e_init [3];
    logic signed [EW-1:0] sxmin, symin, area;
    logic [X_W-1:0]       xmin_c, xmax_c;
    logic [Y_W-1:0]       ymin_c, ymax_c;
    logic                 cull, neg, covered, advance, last_col, last_row;

    // Setup math from the captured vertices; flipping the deltas flips every edge value.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sx[i] = $signed({{(EW-X_W){1'b0}}, vx[i]});
            sy[i] = $signed({{(EW-Y_W){1'b0}}, vy[i]});
        end
        for (int i = 0; i < 3; i++) begin
            dx_raw[i] = sx[(i+1)%3] - sx[i];
            dy_raw[i] = sy[(i+1)%3] - sy[i];
        end
        area = (sx[2] - sx[0]) * dy_raw[0] - (sy[2] - sy[0]) * dx_raw[0];

        xmin_c = vx[0];
        if (vx[1] < xmin_c) xmin_c = vx[1];
        if (vx[2] < xmin_c) xmin_c = vx[2];
        xmax_c = vx[0];
        if (vx[1] > xmax_c) xmax_c = vx[1];
        if (vx[2] > xmax_c) xmax_c = vx[2];
        if (xmax_c > X_LIM) xmax_c = X_LIM;
        ymin_c = vy[0];
        if (vy[1] < ymin_c) ymin_c = vy[1];
        if (vy[2] < ymin_c) ymin_c = vy[2];
        ymax_c = vy[0];
        if (vy[1] > ymax_c) ymax_c = vy[1];
        if (vy[2] > ymax_c) ymax_c = vy[2];
        if (ymax_c > Y_LIM) ymax_c = Y_LIM;

        cull = (area == '0) || (xmin_c > xmax_c) || (ymin_c > ymax_c);
`ifdef RU_BACKFACE_CULL_EN
        neg  = 1'b0;
        cull = cull || area[EW-1];
`else
        neg  = area[EW-1];
`endif
        for (int i = 0; i < 3; i++) begin
            dx_c[i] = neg ? -dx_raw[i] : dx_raw[i];
            dy_c[i] = neg ? -dy_raw[i] : dy_raw[i];
        end
    end

    always_comb begin
        sxmin = $signed({{(EW-X_W){1'b0}}, xmin});
        symin = $signed({{(EW-Y_W){1'b0}}, ymin});
        for (int i = 0; i < 3; i++) begin
            e_init[i] = (sxmin - sx[i]) * dy[i] - (symin - sy[i]) * dx[i];
        end
        covered  = !e[0][EW-1] && !e[1][EW-1] && !e[2][EW-1];
        last_col = (x == xmax);
        last_row = (y == ymax);
    end

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        bus.fb_we  = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = SETUP;
            end
            SETUP: state_next = cull ? DONE : INIT;
            INIT:  state_next = SCAN;
            SCAN: begin
                bus.fb_we = covered;
                advance   = !covered || bus.fb_ready;
                if (advance && last_col && last_row) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.fb_x = x;
    assign bus.fb_y = y;
    assign bus.data = color_q;

    // A stalled covered pixel keeps x, y and the edge values untouched, so the write holds.
    always_ff @(posedge clk) begin
        if (areset) begin
            state   <= IDLE;
            color_q <= '0;
            x       <= '0;
            y       <= '0;
            xmin    <= '0;
            xmax    <= '0;
            ymin    <= '0;
            ymax    <= '0;
            for (int i = 0; i < 3; i++) begin
                vx[i]  <= '0;
                vy[i]  <= '0;
                dx[i]  <= '0;
                dy[i]  <= '0;
                e[i]   <= '0;
                row[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (bus.start) begin
                    vx[0]   <= bus.v0x;
                    vx[1]   <= bus.v1x;
                    vx[2]   <= bus.v2x;
                    vy[0]   <= bus.v0y;
                    vy[1]   <= bus.v1y;
                    vy[2]   <= bus.v2y;
                    color_q <= bus.color;
                end
                SETUP: begin
                    xmin <= xmin_c;
                    xmax <= xmax_c;
                    ymin <= ymin_c;
                    ymax <= ymax_c;
                    for (int i = 0; i < 3; i++) begin
                        dx[i] <= dx_c[i];
                        dy[i] <= dy_c[i];
                    end
                end
                INIT: begin
                    x <= xmin;
                    y <= ymin;
                    for (int i = 0; i < 3; i++) begin
                        e[i]   <= e_init[i];
                        row[i] <= e_init[i];
                    end
                end
                SCAN: if (advance) begin
                    if (!last_col) begin
                        x <= x + 1'b1;
                        for (int i = 0; i < 3; i++) e[i] <= e[i] + dy[i];
                    end else if (!last_row) begin
                        x <= xmin;
                        y <= y + 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            e[i]   <= row[i] - dx[i];
                            row[i] <= row[i] - dx[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_raster_engine.sv
// Self-checking bench for tri_raster_engine: directed triangles plus randomized ones,
// compared against a direct per-pixel edge-function model of the raster rules.
module tb_tri_raster_engine;
    localparam int X_W      = 10;
    localparam int Y_W      = 10;
    localparam int COLOR_W  = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAX_CYC  = 40000;

    logic clk    = 1'b0;
    logic areset = 1'b1;
    int   num_checks = 0;
    int   num_fail   = 0;

    tri_raster_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

    tri_raster_engine #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    bit   exp_cull;
    int   exp_npix;
    int   exp_total;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic longint edgeFn(longint ax, longint ay, longint bx, longint by,
                                      longint px, longint py);
        return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
    endfunction

    // Reference: clamp the box, then test every pixel directly against the three edges.
    function automatic void buildModel(int ax, int ay, int bx, int by, int cx, int cy);
        int xmin, xmax, ymin, ymax;
        longint area, e0, e1, e2;
        longint sgn;
        exp_q.delete();
        xmin = ax; if (bx < xmin) xmin = bx; if (cx < xmin) xmin = cx;
        xmax = ax; if (bx > xmax) xmax = bx; if (cx > xmax) xmax = cx;
        ymin = ay; if (by < ymin) ymin = by; if (cy < ymin) ymin = cy;
        ymax = ay; if (by > ymax) ymax = by; if (cy > ymax) ymax = cy;
        if (xmax > SCREEN_W - 1) xmax = SCREEN_W - 1;
        if (ymax > SCREEN_H - 1) ymax = SCREEN_H - 1;
        area     = edgeFn(ax, ay, bx, by, cx, cy);
        exp_cull = (area == 0) || (xmin > xmax) || (ymin > ymax);
`ifdef RU_BACKFACE_CULL_EN
        if (area < 0) exp_cull = 1'b1;
`endif
        sgn      = (area < 0) ? -1 : 1;
        exp_npix = exp_cull ? 0 : (xmax - xmin + 1) * (ymax - ymin + 1);
        if (!exp_cull) begin
            for (int py = ymin; py <= ymax; py++) begin
                for (int px = xmin; px <= xmax; px++) begin
                    e0 = sgn * edgeFn(ax, ay, bx, by, px, py);
                    e1 = sgn * edgeFn(bx, by, cx, cy, px, py);
                    e2 = sgn * edgeFn(cx, cy, ax, ay, px, py);
                    if (e0 >= 0 && e1 >= 0 && e2 >= 0) exp_q.push_back('{x: px, y: py});
                end
            end
        end
        exp_total = exp_q.size();
    endfunction

    // ready_mode: 0 = always ready, 1 = alternate from first write, 2 = random.
    task automatic applyStimulus(input string name,
                                 input int ax, input int ay, input int bx, input int by,
                                 input int cx, input int cy, input int col,
                                 input int ready_mode, input int reset_at,
                                 output int writes, output int done_cyc);
        int  cyc, stalls, bad, phase, quiet_viol;
        bit  started, rdy;
        buildModel(ax, ay, bx, by, cx, cy);
        writes = 0; stalls = 0; bad = 0; phase = 0; started = 1'b0; done_cyc = -1;

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.v0x = X_W'(ax); bus.v0y = Y_W'(ay);
        bus.v1x = X_W'(bx); bus.v1y = Y_W'(by);
        bus.v2x = X_W'(cx); bus.v2y = Y_W'(cy);
        bus.color = COLOR_W'(col);
        @(posedge clk); #1;
        cyc = 1;
        bus.start = 1'b0;
        checkOutput({name, "_busy_setup"}, longint'(bus.busy), 1);

        while (cyc < MAX_CYC) begin
            if (reset_at >= 0 && cyc == reset_at) break;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            case (ready_mode)
                0: rdy = 1'b1;
                1: begin
                    if (bus.fb_we) started = 1'b1;
                    rdy = !started || (phase % 2 == 0);
                    if (started) phase++;
                end
                default: rdy = ($urandom_range(3) != 0);
            endcase
            bus.fb_ready = rdy;
            if (bus.fb_we) begin
                if (exp_q.size() == 0) bad++;
                else if (int'(bus.fb_x) != exp_q[0].x || int'(bus.fb_y) != exp_q[0].y ||
                         int'(bus.data) != col) bad++;
                if (rdy) begin
                    writes++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    stalls++;
                end
            end
            // Inputs that a busy engine must ignore.
            bus.start = 1'($urandom_range(1));
            bus.v0x = X_W'($urandom); bus.v1x = X_W'($urandom); bus.v2x = X_W'($urandom);
            bus.v0y = Y_W'($urandom); bus.v1y = Y_W'($urandom); bus.v2y = Y_W'($urandom);
            bus.color = COLOR_W'($urandom);
            @(posedge clk); #1;
            cyc++;
        end

        if (reset_at >= 0) begin
            areset    = 1'b1;
            bus.start = 1'b0;
            @(posedge clk); #1;
            checkOutput({name, "_rst_we"},   longint'(bus.fb_we), 0);
            checkOutput({name, "_rst_busy"}, longint'(bus.busy),  0);
            checkOutput({name, "_rst_x"},    longint'(bus.fb_x),  0);
            checkOutput({name, "_rst_data"}, longint'(bus.data),  0);
            checkOutput({name, "_prefix_bad"}, bad, 0);
            areset = 1'b0;
            quiet_viol = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.fb_we || bus.done || bus.busy) quiet_viol++;
            end
            checkOutput({name, "_quiet"}, quiet_viol, 0);
            return;
        end

        checkOutput({name, "_done_cycle"}, done_cyc, exp_cull ? 2 : 3 + exp_npix + stalls);
        checkOutput({name, "_writes"}, writes, exp_total);
        checkOutput({name, "_pixel_bad"}, bad, 0);
        // start during the done cycle must not relaunch.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput({name, "_idle_after"}, longint'(bus.busy), 0);
    endtask

    initial begin
        int w, d;
        int ax, ay;
        int rv[6];
        bus.start = 1'b0;
        bus.v0x = '0; bus.v1x = '0; bus.v2x = '0;
        bus.v0y = '0; bus.v1y = '0; bus.v2y = '0;
        bus.color = '0;
        bus.fb_ready = 1'b1;
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", longint'(bus.busy),  0);
        checkOutput("reset_done", longint'(bus.done),  0);
        checkOutput("reset_we",   longint'(bus.fb_we), 0);
        checkOutput("reset_x",    longint'(bus.fb_x),  0);
        checkOutput("reset_y",    longint'(bus.fb_y),  0);
        checkOutput("reset_data", longint'(bus.data),  0);
        areset = 1'b0;

        $display("[TB] reset mid-scan");
        applyStimulus("midreset", 69, 69, 69, 169, 169, 69, 10, 0, 500, w, d);

        $display("[TB] base triangle");
        applyStimulus("base", 69, 69, 69, 169, 169, 69, 10, 0, -1, w, d);
        checkOutput("base_writes_5151", w, 5151);
        checkOutput("base_done_10204", d, 10204);

        $display("[TB] reversed winding");
        applyStimulus("reversed", 69, 69, 169, 69, 69, 169, 10, 0, -1, w, d);
`ifdef RU_BACKFACE_CULL_EN
        checkOutput("reversed_writes_0", w, 0);
        checkOutput("reversed_done_2", d, 2);
`else
        checkOutput("reversed_writes_5151", w, 5151);
        checkOutput("reversed_done_10204", d, 10204);
`endif

        $display("[TB] backpressure");
        applyStimulus("backpressure", 69, 69, 69, 169, 169, 69, 10, 1, -1, w, d);
        checkOutput("bp_writes_5151", w, 5151);

        $display("[TB] degenerate and off-screen");
        applyStimulus("degenerate", 10, 10, 20, 20, 30, 30, 3, 0, -1, w, d);
        checkOutput("degenerate_done_2", d, 2);
        applyStimulus("offscreen", 700, 10, 800, 10, 700, 50, 3, 0, -1, w, d);
        checkOutput("offscreen_writes_0", w, 0);

        $display("[TB] clamp");
        applyStimulus("clamp", 600, 400, 1000, 400, 600, 1000, 5, 0, -1, w, d);
        checkOutput("clamp_done_3203", d, 3203);

        $display("[TB] random triangles");
        for (int t = 0; t < 6; t++) begin
            ax = ($urandom_range(1) == 1) ? int'($urandom_range(600, 630)) : int'($urandom_range(0, 500));
            ay = ($urandom_range(1) == 1) ? int'($urandom_range(450, 470)) : int'($urandom_range(0, 400));
            for (int k = 0; k < 3; k++) begin
                rv[2*k]   = ax + int'($urandom_range(0, 30));
                rv[2*k+1] = ay + int'($urandom_range(0, 30));
            end
            applyStimulus($sformatf("rand%0d", t), rv[0], rv[1], rv[2], rv[3], rv[4], rv[5],
                          int'($urandom_range(15)), 2, -1, w, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule
